// File: rtl/simple_bus_initiator_parity.sv
// simple_bus_initiator_parity
//   Initiator end of the SIMPLE_TOP bus. Each accepted host command becomes either
//   a write-address + write-data pair of transfers or a read-address transfer
//   followed by a wait for read data. One transaction is in flight at a time, and
//   every transaction ends with a response held on RSP_* until the host takes it.
//   Every outgoing payload carries a parity bit. Returning read data is checked
//   against its parity bit. A mismatch is flagged on RSP_ERR. When enabled, it is
//   also pulsed on the dual-rail pair ERR_RDATA_PARITY / ERR_RDATA_PARITY_B.
//
// Optional feature (macro SIMPLE_INIT_TIMEOUT_EN):
//   When defined, a read that waits RD_TIMEOUT cycles in RD_WAIT without data is
//   abandoned. It completes with RSP_ERR=1 and RSP_RDATA=0. When undefined,
//   RD_WAIT waits indefinitely.
//
// Ports:
//   ACLK, RESETN_ACLK              clock, synchronous active-low reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA   host command
//   RSP_VALID/READY/WRITE/RDATA/ERR    host response
//   WADDR_*, WDATA_*, RADDR_*      outgoing channels (valid/data/parity, ready in)
//   RDATA_VALID/DATA/PARITY, RDATA_READY   returning read data
//   ENERR_RDATA_PARITY             enables the error pulse
//   FIERR_WADDR_PARITY             inverts WADDR_PARITY while high
//   ERR_RDATA_PARITY, ERR_RDATA_PARITY_B   one-cycle error pulse, dual rail
module simple_bus_initiator_parity #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int RD_TIMEOUT = 255
) (
  input  logic        ACLK,
  input  logic        RESETN_ACLK,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [63:0] CMD_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_WRITE,
  output logic [63:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        WADDR_VALID,
  output logic [31:0] WADDR_DATA,
  output logic        WADDR_PARITY,
  input  logic        WADDR_READY,
  output logic        WDATA_VALID,
  output logic [63:0] WDATA_DATA,
  output logic        WDATA_PARITY,
  input  logic        WDATA_READY,
  output logic        RADDR_VALID,
  output logic [31:0] RADDR_DATA,
  output logic        RADDR_PARITY,
  input  logic        RADDR_READY,
  input  logic        RDATA_VALID,
  input  logic [63:0] RDATA_DATA,
  input  logic        RDATA_PARITY,
  output logic        RDATA_READY,
  input  logic        ENERR_RDATA_PARITY,
  input  logic        FIERR_WADDR_PARITY,
  output logic        ERR_RDATA_PARITY,
  output logic        ERR_RDATA_PARITY_B
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        waddr_valid_q, waddr_valid_d;
  logic        wdata_valid_q, wdata_valid_d;
  logic        raddr_valid_q, raddr_valid_d;
  logic        rdata_ready_q, rdata_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic        err_q, err_d;
  logic        err_b_q, err_b_d;
  logic        rdata_mismatch;

`ifdef SIMPLE_INIT_TIMEOUT_EN
  localparam logic [15:0] RD_LIMIT = 16'(RD_TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Expected parity of the incoming beat under the configured sense.
  assign rdata_mismatch = RDATA_PARITY != ((^RDATA_DATA) ^ PARITY_ODD);

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    waddr_valid_d = waddr_valid_q;
    wdata_valid_d = wdata_valid_q;
    raddr_valid_d = raddr_valid_q;
    rdata_ready_d = rdata_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_err_d     = rsp_err_q;
    rsp_rdata_d   = rsp_rdata_q;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    raddr_d       = raddr_q;
    err_d         = 1'b0;
`ifdef SIMPLE_INIT_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (CMD_WRITE) begin
            waddr_d       = CMD_ADDR;
            wdata_d       = CMD_WDATA;
            waddr_valid_d = 1'b1;
            state_d       = S_WR_ADDR;
          end else begin
            raddr_d       = CMD_ADDR;
            raddr_valid_d = 1'b1;
            state_d       = S_RD_ADDR;
          end
        end
      end

      S_WR_ADDR: begin
        if (WADDR_READY) begin
          waddr_valid_d = 1'b0;
          wdata_valid_d = 1'b1;
          state_d       = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (WDATA_READY) begin
          wdata_valid_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_rdata_d   = '0;
          state_d       = S_RSP;
        end
      end

      S_RD_ADDR: begin
        if (RADDR_READY) begin
          raddr_valid_d = 1'b0;
          rdata_ready_d = 1'b1;
          state_d       = S_RD_WAIT;
`ifdef SIMPLE_INIT_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end

      S_RD_WAIT: begin
        // A beat takes priority over a timeout that expires in the same cycle.
        if (RDATA_VALID) begin
          rdata_ready_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = RDATA_DATA;
          rsp_err_d     = rdata_mismatch;
          err_d         = rdata_mismatch & ENERR_RDATA_PARITY;
          state_d       = S_RSP;
        end
`ifdef SIMPLE_INIT_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          // Abort at the end of the RD_TIMEOUT-th wait cycle.
          if (cnt_d == RD_LIMIT) begin
            rdata_ready_d = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = 1'b0;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            state_d       = S_RSP;
          end
        end
`endif
      end

      S_RSP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d       = S_IDLE;
        cmd_ready_d   = 1'b1;
        waddr_valid_d = 1'b0;
        wdata_valid_d = 1'b0;
        raddr_valid_d = 1'b0;
        rdata_ready_d = 1'b0;
        rsp_valid_d   = 1'b0;
      end
    endcase

    err_b_d = ~err_d;
  end

  always_ff @(posedge ACLK) begin
    if (!RESETN_ACLK) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      waddr_valid_q <= 1'b0;
      wdata_valid_q <= 1'b0;
      raddr_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      raddr_q       <= '0;
      err_q         <= 1'b0;
      err_b_q       <= 1'b1;
`ifdef SIMPLE_INIT_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      waddr_valid_q <= waddr_valid_d;
      wdata_valid_q <= wdata_valid_d;
      raddr_valid_q <= raddr_valid_d;
      rdata_ready_q <= rdata_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      raddr_q       <= raddr_d;
      err_q         <= err_d;
      err_b_q       <= err_b_d;
`ifdef SIMPLE_INIT_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign CMD_READY          = cmd_ready_q;
  assign RSP_VALID          = rsp_valid_q;
  assign RSP_WRITE          = rsp_write_q;
  assign RSP_RDATA          = rsp_rdata_q;
  assign RSP_ERR            = rsp_err_q;
  assign WADDR_VALID        = waddr_valid_q;
  assign WADDR_DATA         = waddr_q;
  assign WDATA_VALID        = wdata_valid_q;
  assign WDATA_DATA         = wdata_q;
  assign RADDR_VALID        = raddr_valid_q;
  assign RADDR_DATA         = raddr_q;
  assign RDATA_READY        = rdata_ready_q;
  assign ERR_RDATA_PARITY   = err_q;
  assign ERR_RDATA_PARITY_B = err_b_q;

  // Parity is derived from the held payload registers. The fault-inject input
  // only touches the write-address channel.
  assign WADDR_PARITY = (^waddr_q) ^ PARITY_ODD ^ FIERR_WADDR_PARITY;
  assign WDATA_PARITY = (^wdata_q) ^ PARITY_ODD;
  assign RADDR_PARITY = (^raddr_q) ^ PARITY_ODD;

endmodule

// File: tb/tb_simple_bus_initiator_parity.sv
module tb_simple_bus_initiator_parity;

  logic        ACLK = 1'b0;
  logic        RESETN_ACLK = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0;
  logic [63:0] CMD_WDATA = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic        RSP_WRITE;
  logic [63:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        WADDR_VALID;
  logic [31:0] WADDR_DATA;
  logic        WADDR_PARITY;
  logic        WADDR_READY = 1'b1;
  logic        WDATA_VALID;
  logic [63:0] WDATA_DATA;
  logic        WDATA_PARITY;
  logic        WDATA_READY = 1'b1;
  logic        RADDR_VALID;
  logic [31:0] RADDR_DATA;
  logic        RADDR_PARITY;
  logic        RADDR_READY = 1'b1;
  logic        RDATA_VALID = 1'b0;
  logic [63:0] RDATA_DATA = '0;
  logic        RDATA_PARITY = 1'b0;
  logic        RDATA_READY;
  logic        ENERR_RDATA_PARITY = 1'b0;
  logic        FIERR_WADDR_PARITY = 1'b0;
  logic        ERR_RDATA_PARITY;
  logic        ERR_RDATA_PARITY_B;

  simple_bus_initiator_parity #(.PARITY_ODD(1'b0), .RD_TIMEOUT(4)) dut (
    .ACLK(ACLK), .RESETN_ACLK(RESETN_ACLK),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .WADDR_VALID(WADDR_VALID), .WADDR_DATA(WADDR_DATA), .WADDR_PARITY(WADDR_PARITY),
    .WADDR_READY(WADDR_READY),
    .WDATA_VALID(WDATA_VALID), .WDATA_DATA(WDATA_DATA), .WDATA_PARITY(WDATA_PARITY),
    .WDATA_READY(WDATA_READY),
    .RADDR_VALID(RADDR_VALID), .RADDR_DATA(RADDR_DATA), .RADDR_PARITY(RADDR_PARITY),
    .RADDR_READY(RADDR_READY),
    .RDATA_VALID(RDATA_VALID), .RDATA_DATA(RDATA_DATA), .RDATA_PARITY(RDATA_PARITY),
    .RDATA_READY(RDATA_READY),
    .ENERR_RDATA_PARITY(ENERR_RDATA_PARITY), .FIERR_WADDR_PARITY(FIERR_WADDR_PARITY),
    .ERR_RDATA_PARITY(ERR_RDATA_PARITY), .ERR_RDATA_PARITY_B(ERR_RDATA_PARITY_B)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        w;
    logic [63:0] d;
    logic        e;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a response is consumed on the posedge that follows a
  // cycle where RSP_VALID and RSP_READY are both high.
  initial begin
    rsp_t e;
    forever begin
      @(negedge ACLK);
      #1;
      if (RESETN_ACLK && RSP_VALID && RSP_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got write=%0b data=%h err=%0b, required no response",
                   RSP_WRITE, RSP_RDATA, RSP_ERR);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_write", {63'd0, RSP_WRITE}, {63'd0, e.w});
          chk("rsp_rdata", RSP_RDATA, e.d);
          chk("rsp_err", {63'd0, RSP_ERR}, {63'd0, e.e});
          $display("rsp: write=%0b rdata=%h err=%0b", RSP_WRITE, RSP_RDATA, RSP_ERR);
        end
      end
    end
  end

  // Drive a command at the current negedge. The DUT accepts it on the next
  // posedge. Returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [63:0] data);
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = data;
    @(negedge ACLK);
    CMD_VALID = 1'b0;
    $display("cmd: write=%0b addr=%h data=%h", wr, addr, data);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(CMD_READY && !RSP_VALID) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("back_to_idle", {63'd0, CMD_READY}, 64'd1);
  endtask

  // Run a read to completion while watching the error pair.
  task automatic rd_observe(input int exp_pulses);
    int pulses = 0;
    logic seen = 1'b0;
    logic err_at_rsp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ERR_RDATA_PARITY) pulses++;
      chk("err_dual_rail", {63'd0, ERR_RDATA_PARITY_B}, {63'd0, ~ERR_RDATA_PARITY});
      if (RSP_VALID && !seen) begin
        seen = 1'b1;
        err_at_rsp = ERR_RDATA_PARITY;
      end
      if (CMD_READY) break;
      @(negedge ACLK);
    end
    chk("err_pulse_count", 64'(pulses), 64'(exp_pulses));
    chk("err_pulse_timing", {63'd0, err_at_rsp}, (exp_pulses > 0) ? 64'd1 : 64'd0);
    chk("rd_done", {63'd0, CMD_READY}, 64'd1);
  endtask

  initial begin
    logic [31:0] hold_addr;
    int n;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    RESETN_ACLK = 1'b1;

    // Reset state
    chk("rst_cmd_ready", {63'd0, CMD_READY}, 64'd1);
    chk("rst_valids", {60'd0, WADDR_VALID, WDATA_VALID, RADDR_VALID, RSP_VALID}, 64'd0);
    chk("rst_rdata_ready", {63'd0, RDATA_READY}, 64'd0);
    chk("rst_err", {62'd0, ERR_RDATA_PARITY, ERR_RDATA_PARITY_B}, 64'd1);
    chk("rst_parity", {61'd0, WADDR_PARITY, WDATA_PARITY, RADDR_PARITY}, 64'd0);
    chk("rst_rsp", RSP_RDATA, 64'd0);

    // 1: write, all readies high; 3-cycle latency
    exp_q.push_back('{w: 1'b1, d: 64'd0, e: 1'b0});
    issue(1'b1, 32'h0000_1000, 64'hFFFF_0000_0000_0001);
    chk("t1_cmd_ready_low", {63'd0, CMD_READY}, 64'd0);
    chk("t1_waddr_valid", {63'd0, WADDR_VALID}, 64'd1);
    chk("t1_waddr_data", {32'd0, WADDR_DATA}, 64'h1000);
    chk("t1_waddr_parity", {63'd0, WADDR_PARITY}, 64'd1);
    chk("t1_rsp_early1", {63'd0, RSP_VALID}, 64'd0);
    @(negedge ACLK);
    chk("t1_wdata_valid", {62'd0, WADDR_VALID, WDATA_VALID}, 64'd1);
    chk("t1_wdata_data", WDATA_DATA, 64'hFFFF_0000_0000_0001);
    chk("t1_wdata_parity", {63'd0, WDATA_PARITY}, 64'd1);
    chk("t1_rsp_early2", {63'd0, RSP_VALID}, 64'd0);
    @(negedge ACLK);
    chk("t1_rsp_valid_lat3", {63'd0, RSP_VALID}, 64'd1);
    chk("t1_rsp_write", {63'd0, RSP_WRITE}, 64'd1);
    wait_idle();

    // 2: address channel stalled for 5 cycles, then response back-pressured
    WADDR_READY = 1'b0;
    RSP_READY = 1'b0;
    exp_q.push_back('{w: 1'b1, d: 64'd0, e: 1'b0});
    issue(1'b1, 32'h2000_0004, 64'h1234);
    hold_addr = WADDR_DATA;
    chk("t2_waddr_captured", {32'd0, hold_addr}, 64'h2000_0004);
    chk("t2_waddr_parity", {63'd0, WADDR_PARITY}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_waddr_valid_held", {63'd0, WADDR_VALID}, 64'd1);
      chk("t2_waddr_data_held", {32'd0, WADDR_DATA}, {32'd0, hold_addr});
      chk("t2_wdata_idle", {63'd0, WDATA_VALID}, 64'd0);
      if (i < 4) @(negedge ACLK);
    end
    WADDR_READY = 1'b1;
    @(negedge ACLK);
    chk("t2_wdata_parity", {63'd0, WDATA_PARITY}, 64'd1);
    n = 0;
    while (!RSP_VALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("t2_rsp_held", {62'd0, RSP_VALID, RSP_WRITE}, 64'd3);
      @(negedge ACLK);
    end
    RSP_READY = 1'b1;
    wait_idle();

    // 3: read, good parity, ERR enabled -> no pulse
    ENERR_RDATA_PARITY = 1'b1;
    RDATA_VALID = 1'b1;
    RDATA_DATA = 64'h3;
    RDATA_PARITY = 1'b0;
    exp_q.push_back('{w: 1'b0, d: 64'h3, e: 1'b0});
    issue(1'b0, 32'h3, 64'd0);
    chk("t3_raddr", {31'd0, RADDR_VALID, RADDR_DATA}, 64'h1_0000_0003);
    chk("t3_raddr_parity", {63'd0, RADDR_PARITY}, 64'd0);
    rd_observe(0);

    // 4a: bad parity with ERR enabled -> one pulse
    RDATA_PARITY = 1'b1;
    exp_q.push_back('{w: 1'b0, d: 64'h3, e: 1'b1});
    issue(1'b0, 32'h3, 64'd0);
    rd_observe(1);

    // 4b: bad parity with ERR disabled -> RSP_ERR only
    ENERR_RDATA_PARITY = 1'b0;
    exp_q.push_back('{w: 1'b0, d: 64'h3, e: 1'b1});
    issue(1'b0, 32'h3, 64'd0);
    rd_observe(0);

    // top-bit data with correct parity, odd-weight read address
    ENERR_RDATA_PARITY = 1'b1;
    RDATA_DATA = 64'h8000_0000_0000_0000;
    RDATA_PARITY = 1'b1;
    exp_q.push_back('{w: 1'b0, d: 64'h8000_0000_0000_0000, e: 1'b0});
    issue(1'b0, 32'h7, 64'd0);
    chk("t4c_raddr_parity", {63'd0, RADDR_PARITY}, 64'd1);
    rd_observe(0);
    RDATA_VALID = 1'b0;

    // 5: fault inject affects only WADDR parity
    FIERR_WADDR_PARITY = 1'b1;
    exp_q.push_back('{w: 1'b1, d: 64'd0, e: 1'b0});
    issue(1'b1, 32'h0, 64'h3);
    chk("t5_waddr_parity_inj", {63'd0, WADDR_PARITY}, 64'd1);
    chk("t5_raddr_parity_clean", {63'd0, RADDR_PARITY}, 64'd1);
    @(negedge ACLK);
    chk("t5_wdata_parity_clean", {63'd0, WDATA_PARITY}, 64'd0);
    FIERR_WADDR_PARITY = 1'b0;
    @(negedge ACLK);
    chk("t5_waddr_parity_off", {63'd0, WADDR_PARITY}, 64'd0);
    wait_idle();

    // 6: reset while waiting for read data drops the transaction
    issue(1'b0, 32'h40, 64'd0);
    n = 0;
    while (!RDATA_READY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("t6_in_rd_wait", {63'd0, RDATA_READY}, 64'd1);
    RESETN_ACLK = 1'b0;
    @(negedge ACLK);
    RESETN_ACLK = 1'b1;
    chk("t6_rst_idle", {61'd0, CMD_READY, RDATA_READY, RADDR_VALID}, 64'd4);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_rsp", {63'd0, RSP_VALID}, 64'd0);
      @(negedge ACLK);
    end

`ifdef SIMPLE_INIT_TIMEOUT_EN
    // timeout after RD_TIMEOUT=4 wait cycles, no pulse
    ENERR_RDATA_PARITY = 1'b1;
    exp_q.push_back('{w: 1'b0, d: 64'd0, e: 1'b1});
    issue(1'b0, 32'h44, 64'd0);
    n = 0;
    for (int i = 0; i < 30 && !RSP_VALID; i++) begin
      if (RDATA_READY) n++;
      chk("to_no_pulse", {63'd0, ERR_RDATA_PARITY}, 64'd0);
      @(negedge ACLK);
    end
    chk("to_wait_cycles", 64'(n), 64'd4);
    chk("to_rsp_valid", {63'd0, RSP_VALID}, 64'd1);
    wait_idle();
`endif

    repeat (3) @(negedge ACLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
